weight_bank_dbuf: RTL and testbench
===================================

// Module: weight_bank_dbuf
// PURPOSE
// - Double-buffered, multi-lane weight store feeding the vector multiplier array.
// - Weights stream in serially over a valid/ready port into a shadow bank.
// - A swap commits the full shadow bank to the active bank in one cycle, so the
//   multipliers see a stable weight vector while the next set loads.
// PARAMETERS
// - WEIGHT_BW  8  signed weight width in bits
// - NUM_LANES  4  weights per vector (>=2); also the number of multiplier lanes
// - IDX_BW     $clog2(NUM_LANES)  derived width of the write index; not overridden
// PORTS
// - clk          in   1                    rising-edge clock
// - rst          in   1                    reset: synchronous, active-high
// - w_valid      in   1                    w_data is valid this cycle
// - w_ready      out  1                    bank accepts w_data this cycle
// - w_data       in   WEIGHT_BW            signed weight; lane order 0..NUM_LANES-1
// - swap_req     in   1                    request shadow->active commit (pulse or level)
// - swap_ack     out  1                    one-cycle pulse: commit happened this edge
// - shadow_full  out  1                    all NUM_LANES shadow lanes written
// - active_vld   out  1                    active bank holds a committed vector
// - weights_out  out  NUM_LANES*WEIGHT_BW  active bank, flat; lane i at [i*WEIGHT_BW +: WEIGHT_BW]
// BEHAVIOUR
// - Reset: every shadow and active lane = 0; wr_idx = 0; state = LOAD;
//   w_ready = 1; swap_ack = 0; shadow_full = 0; active_vld = 0.
// - Reset wins over all other inputs. A reset mid-load discards the partial
//   shadow vector. A reset after a commit clears the active bank to 0.
// - States: LOAD (accepting), FULL (shadow complete, waiting for swap).
// - Write handshake: a transfer occurs when w_valid && w_ready.
//   - On a transfer, shadow[wr_idx] <= w_data and wr_idx increments.
//   - w_ready = (state == LOAD) and is combinational from state only.
//   - w_ready does not depend on w_valid or swap_req.
// - LOAD -> FULL on the transfer with wr_idx == NUM_LANES-1.
//   - On that transfer wr_idx wraps to 0.
//   - shadow_full goes to 1 on the following cycle.
// - In FULL: w_ready = 0; w_data is ignored; the shadow bank is held.
// - Commit condition: swap_req && state == FULL. On that edge:
//   - active <= shadow (all lanes);
//   - active_vld <= 1; swap_ack <= 1 for exactly one cycle;
//   - state -> LOAD, so w_ready = 1 on the next cycle.
// - Commit latency: swap_req sampled in FULL gives the new weights_out and the
//   swap_ack pulse on the next cycle.
// - swap_req in LOAD, including the same cycle as the last write, is ignored:
//   no ack, no change to the active bank. The caller keeps swap_req high or
//   re-issues it.
// - swap_req held high across several FULL cycles commits once; the FSM leaves
//   FULL on that edge.
// - The shadow bank is not cleared on commit. It is overwritten lane by lane
//   during the next load.
// - weights_out changes only on a commit or on reset. It never glitches during
//   a load.
// - Data is stored verbatim: no sign extension, no arithmetic.
// STRUCTURE
// - Shared package wbuf_pkg:
//   - state encoding localparams ST_LOAD = 1'b0, ST_FULL = 1'b1;
//   - default WEIGHT_BW and NUM_LANES constants shared with the multiplier array.
// - One sub-module, weight_lane_reg:
//   - a single WEIGHT_BW register with clk, rst (sync, active-high), load enable, d, q;
//   - instantiated 2*NUM_LANES times via generate (shadow and active banks).
// - FSM, wr_idx counter and the swap_ack register live in the top module.
// TESTING (WEIGHT_BW=8, NUM_LANES=4)
// - Reset: after rst, weights_out=0, active_vld=0, w_ready=1, shadow_full=0, swap_ack=0.
// - Basic load and swap:
//   - stream 0x01,0x7F,0x80,0xFF with w_valid held -> shadow_full=1 and w_ready=0 next cycle;
//   - swap_req -> next cycle weights_out=0xFF807F01, swap_ack=1 for one cycle, active_vld=1.
// - Backpressure while FULL: drive w_valid=1 with 0x55 for 3 cycles -> w_ready=0,
//   no shadow change, and a later swap still yields 0xFF807F01.
// - Early swap: swap_req on the same cycle as the 4th write -> no ack, weights_out unchanged;
//   swap_req on the next cycle -> commit occurs.
// - Overlap: after a commit, load 0x10,0x20,0x30,0x40 with gaps in w_valid ->
//   weights_out stays 0xFF807F01 throughout; after swap it reads 0x40302010.
// - Mid-load reset: write 2 lanes, assert rst for 1 cycle, then write 4 lanes and swap ->
//   only the post-reset 4 values appear, and wr_idx restarted at lane 0.

Source files
------------

// File: rtl/wbuf_pkg.sv
// Shared definitions for the double-buffered weight bank and the
// multiplier array that consumes its output.
package wbuf_pkg;

  // Default geometry shared with the vector multiplier array
  localparam int WBUF_WEIGHT_BW = 8;
  localparam int WBUF_NUM_LANES = 4;

  // Bank controller states: LOAD accepts serial weights, FULL waits for a swap
  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_FULL = 1'b1
  } wbuf_state_e;

endpackage : wbuf_pkg

// File: rtl/weight_lane_reg.sv
// One weight register with a load enable; used for both shadow and active lanes.
module weight_lane_reg #(
  parameter int WEIGHT_BW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WEIGHT_BW-1:0] d,
  output logic [WEIGHT_BW-1:0] q
);

  logic [WEIGHT_BW-1:0] q_q;
  logic [WEIGHT_BW-1:0] q_d;

  // Take the new value only when enabled, otherwise hold
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  // Register with synchronous clear so a reset empties the lane
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : weight_lane_reg

// File: rtl/weight_bank_dbuf.sv
// Double-buffered weight store: weights stream serially into a shadow bank
// and a swap copies the whole shadow bank into the active bank in one edge,
// so the multipliers always see a stable vector while the next one loads.
module weight_bank_dbuf
  import wbuf_pkg::*;
#(
  parameter int WEIGHT_BW = WBUF_WEIGHT_BW,
  parameter int NUM_LANES = WBUF_NUM_LANES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           w_valid,
  output logic                           w_ready,
  input  logic [WEIGHT_BW-1:0]           w_data,
  input  logic                           swap_req,
  output logic                           swap_ack,
  output logic                           shadow_full,
  output logic                           active_vld,
  output logic [NUM_LANES*WEIGHT_BW-1:0] weights_out
);

  localparam int IDX_BW = $clog2(NUM_LANES);
  localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(NUM_LANES - 1);

  wbuf_state_e       state_q;
  wbuf_state_e       state_d;
  logic [IDX_BW-1:0] wr_idx_q;
  logic [IDX_BW-1:0] wr_idx_d;
  logic              swap_ack_q;
  logic              swap_ack_d;
  logic              active_vld_q;
  logic              active_vld_d;
  logic              shadow_full_q;
  logic              shadow_full_d;

  logic              transfer;
  logic              commit;
  logic              last_lane;

  logic [WEIGHT_BW-1:0] shadow_w [NUM_LANES];

  // Ready depends only on state, so the writer never sees a combinational loop
  assign w_ready   = (state_q == ST_LOAD);
  assign transfer  = w_valid && w_ready;
  assign commit    = swap_req && (state_q == ST_FULL);
  assign last_lane = (wr_idx_q == LAST_IDX);

  // Next-state logic for the controller, write index and status flags
  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    swap_ack_d    = 1'b0;
    active_vld_d  = active_vld_q;
    shadow_full_d = shadow_full_q;
    case (state_q)
      ST_LOAD: begin
        if (transfer) begin
          if (last_lane) begin
            wr_idx_d      = '0;
            state_d       = ST_FULL;
            shadow_full_d = 1'b1;
          end else begin
            wr_idx_d = wr_idx_q + IDX_BW'(1);
          end
        end
      end
      ST_FULL: begin
        if (commit) begin
          state_d       = ST_LOAD;
          shadow_full_d = 1'b0;
          swap_ack_d    = 1'b1;
          active_vld_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Controller registers; reset discards any partial load and the active vector
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_LOAD;
      wr_idx_q      <= '0;
      swap_ack_q    <= 1'b0;
      active_vld_q  <= 1'b0;
      shadow_full_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      swap_ack_q    <= swap_ack_d;
      active_vld_q  <= active_vld_d;
      shadow_full_q <= shadow_full_d;
    end
  end

  assign swap_ack    = swap_ack_q;
  assign active_vld  = active_vld_q;
  assign shadow_full = shadow_full_q;

  // Shadow lanes load one at a time by index; active lanes all load on commit
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    weight_lane_reg #(
      .WEIGHT_BW(WEIGHT_BW)
    ) u_shadow (
      .clk(clk),
      .rst(rst),
      .en (transfer && (wr_idx_q == IDX_BW'(i))),
      .d  (w_data),
      .q  (shadow_w[i])
    );

    weight_lane_reg #(
      .WEIGHT_BW(WEIGHT_BW)
    ) u_active (
      .clk(clk),
      .rst(rst),
      .en (commit),
      .d  (shadow_w[i]),
      .q  (weights_out[i*WEIGHT_BW +: WEIGHT_BW])
    );
  end

endmodule : weight_bank_dbuf

// File: tb/tb_weight_bank_dbuf.sv
// Directed bench for weight_bank_dbuf with WEIGHT_BW=8, NUM_LANES=4.
module tb_weight_bank_dbuf;

  logic        clk;
  logic        rst;
  logic        w_valid;
  logic        w_ready;
  logic [7:0]  w_data;
  logic        swap_req;
  logic        swap_ack;
  logic        shadow_full;
  logic        active_vld;
  logic [31:0] weights_out;

  int total;
  int bad;

  weight_bank_dbuf #(
    .WEIGHT_BW(8),
    .NUM_LANES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .shadow_full(shadow_full),
    .active_vld (active_vld),
    .weights_out(weights_out)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs, advance one edge and settle 1 time unit past it
  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d, input logic s);
    rst      = r;
    w_valid  = v;
    w_data   = d;
    swap_req = s;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Check every status output at once
  task automatic checkStatus(input string tag, input logic [31:0] wout, input logic rdy,
                             input logic full, input logic ack, input logic vld);
    checkOutput({tag, "_weights"}, weights_out, wout);
    checkOutput({tag, "_ready"}, {31'd0, w_ready}, {31'd0, rdy});
    checkOutput({tag, "_full"}, {31'd0, shadow_full}, {31'd0, full});
    checkOutput({tag, "_ack"}, {31'd0, swap_ack}, {31'd0, ack});
    checkOutput({tag, "_vld"}, {31'd0, active_vld}, {31'd0, vld});
  endtask

  // Directed sequence
  initial begin
    logic [7:0] vec_a [4];
    logic [7:0] vec_b [4];
    logic       gaps  [8];
    int         k;
    total = 0;
    bad   = 0;
    vec_a = '{8'h01, 8'h7F, 8'h80, 8'hFF};
    vec_b = '{8'h10, 8'h20, 8'h30, 8'h40};
    gaps  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; w_valid = 1'b0; w_data = 8'h00; swap_req = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    checkStatus("reset", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] basic load with held w_valid");
    for (int i = 0; i < 4; i++) begin
      checkOutput("load_a_ready", {31'd0, w_ready}, 32'd1);
      applyStimulus(1'b0, 1'b1, vec_a[i], 1'b0);
    end
    checkStatus("load_a_done", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("[TB] backpressure while full");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h55, 1'b0);
      checkStatus("bp_hold", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkStatus("swap_a", 32'hFF807F01, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkStatus("swap_a_after", 32'hFF807F01, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] early swap on the last write");
    applyStimulus(1'b0, 1'b1, 8'h11, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h22, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h33, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h44, 1'b1);
    checkStatus("early_ignored", 32'hFF807F01, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkStatus("early_commit", 32'h44332211, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkStatus("swap_level_in_load", 32'h44332211, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] overlapped load with gaps");
    k = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, gaps[i], gaps[i] ? vec_b[k] : 8'hEE, 1'b0);
      if (gaps[i]) k++;
      checkOutput("overlap_stable", weights_out, 32'h44332211);
    end
    checkStatus("overlap_full", 32'h44332211, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkStatus("swap_b", 32'h40302010, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkStatus("swap_b_held", 32'h40302010, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] mid-load reset");
    applyStimulus(1'b0, 1'b1, 8'hAA, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hBB, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hEE, 1'b1);
    checkStatus("mid_reset", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h02, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h03, 1'b0);
    checkStatus("post_reset_partial", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h04, 1'b0);
    checkStatus("post_reset_full", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkStatus("swap_c", 32'h04030201, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_weight_bank_dbuf
